// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
//
// Purpose: frame width, byte type, responder FSM state encoding and the
// default byte shifted out when no response is queued.

package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef logic [SPI_WIDTH-1:0] spi_byte_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam spi_byte_t DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flop synchronizer for asynchronous inputs
//
// Purpose: brings a WIDTH-bit asynchronous bus into the clk domain through
// STAGES flops (STAGES >= 2). RESET_VAL lets idle-high inputs such as a
// chip select reset to their inactive level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset
//   d    - asynchronous input bus
//   q    - synchronized output bus

module sync_ff #(
    parameter int                STAGES    = 2,
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI mode-0 responder with a 1-deep tx buffer
//
// Purpose: samples SCLK/MOSI/CS in the clk domain, receives MSB-first bytes
// and shifts queued response bytes out on MISO; several bytes per CS frame.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   spi_sclk     - serial clock from master (idle low)
//   spi_mosi     - master-out data
//   spi_miso     - slave-out data, 0 outside a frame
//   spi_cs       - chip select, active low
//   tx_byte      - response byte to queue, written when tx_valid && tx_ready
//   tx_valid     - tx_byte is valid
//   tx_ready     - tx buffer empty
//   rx_byte      - last received byte, held until the next completion
//   rx_valid     - one-cycle strobe: rx_byte updated
//   tx_underrun  - one-cycle strobe: IDLE_BYTE loaded because buffer was empty
//   frame_err    - one-cycle strobe: CS released mid-byte
//   busy         - synchronized CS asserted

module spi_slave
    import spi_pkg::*;
#(
    parameter int        SYNC_STAGES = 2,
    parameter spi_byte_t IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      spi_sclk,
    input  logic      spi_mosi,
    output logic      spi_miso,
    input  logic      spi_cs,
    input  spi_byte_t tx_byte,
    input  logic      tx_valid,
    output logic      tx_ready,
    output spi_byte_t rx_byte,
    output logic      rx_valid,
    output logic      tx_underrun,
    output logic      frame_err,
    output logic      busy
);

    // Synchronized pins, packed as {cs, mosi, sclk}. CS resets high so a
    // reset never looks like a chip-select edge.
    logic [2:0] pins_raw;
    logic [2:0] pins_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       cs_s;

    assign pins_raw = {spi_cs, spi_mosi, spi_sclk};

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (3),
        .RESET_VAL (3'b100)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pins_raw),
        .q   (pins_s)
    );

    assign sclk_s = pins_s[0];
    assign mosi_s = pins_s[1];
    assign cs_s   = pins_s[2];

    spi_state_t state_q;
    spi_state_t state_d;
    logic       sclk_prev_q;
    logic       cs_prev_q;
    spi_byte_t  tx_shift_q;
    // Only seven bits are kept: the eighth completes straight into rx_byte.
    logic [SPI_WIDTH-2:0] rx_shift_q;
    logic [2:0] bit_cnt_q;
    spi_byte_t  buf_q;
    logic       buf_full_q;
    spi_byte_t  rx_byte_q;
    logic       rx_valid_q;
    logic       tx_underrun_q;
    logic       frame_err_q;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic start_frame;
    logic end_frame;
    logic load_tx;
    logic shift_tx;
    logic sample_rx;
    spi_byte_t load_byte;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;

    // A load always takes the buffer content as it stands this cycle; a
    // simultaneous write only lands afterwards.
    assign load_byte = buf_full_q ? buf_q : IDLE_BYTE;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        sample_rx   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_SHIFT;
                    start_frame = 1'b1;
                    load_tx     = 1'b1;
                end
            end
            ST_SHIFT: begin
                // CS release takes priority over any sclk edge seen in the
                // same cycle.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    end_frame = 1'b1;
                end else if (sclk_rise) begin
                    sample_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        load_tx = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= 3'd0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;

            if (start_frame) begin
                bit_cnt_q  <= 3'd0;
                rx_shift_q <= '0;
            end

            if (load_tx) begin
                tx_shift_q <= load_byte;
                if (!buf_full_q) begin
                    tx_underrun_q <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_shift_q <= tx_shift_q << 1;
            end

            if (sample_rx) begin
                rx_shift_q <= {rx_shift_q[SPI_WIDTH-3:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_q  <= {rx_shift_q, mosi_s};
                    rx_valid_q <= 1'b1;
                end
            end

            if (end_frame) begin
                bit_cnt_q   <= 3'd0;
                rx_shift_q  <= '0;
                tx_shift_q  <= '0;
                frame_err_q <= (bit_cnt_q != 3'd0);
            end

            // Write and load can never both touch buf_full in one cycle:
            // a write needs it clear, a load only clears it when set.
            if (load_tx && buf_full_q) begin
                buf_full_q <= 1'b0;
            end else if (tx_valid && !buf_full_q) begin
                buf_q      <= tx_byte;
                buf_full_q <= 1'b1;
            end
        end
    end

    assign spi_miso    = (state_q == ST_SHIFT) & tx_shift_q[SPI_WIDTH-1];
    assign tx_ready    = ~buf_full_q;
    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave

module tb_spi_slave;
    import spi_pkg::*;

    localparam int         H    = 4;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave #(
        .SYNC_STAGES (2),
        .IDLE_BYTE   (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_cs      (spi_cs),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    int dut_rxv = 0;
    int dut_ur  = 0;
    int dut_fe  = 0;
    int exp_ur  = 0;
    int exp_fe  = 0;
    int ur_at_start = 0;

    // Model: the responder's tx buffer, bytes the master has fully sent, and
    // the expected strobe counts.
    logic       m_full = 1'b0;
    logic [7:0] m_buf  = 8'h00;
    logic [7:0] exp_rx [$];

    logic [7:0] mo  [4];
    logic [7:0] got [4];

    logic busy_d = 1'b0;
    logic rxv_d  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_load(output logic [7:0] slot);
        if (m_full) begin
            slot   = m_buf;
            m_full = 1'b0;
        end else begin
            slot = IDLE;
            exp_ur++;
        end
    endtask

    task automatic tx_write(input logic [7:0] v);
        tx_byte  = v;
        tx_valid = 1'b1;
        chk("tx_ready_before_write", tx_ready, !m_full);
        if (!m_full) begin
            m_buf  = v;
            m_full = 1'b1;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miso"},      spi_miso,    0);
        chk({tag, "_tx_ready"},  tx_ready,    1);
        chk({tag, "_rx_byte"},   rx_byte,     0);
        chk({tag, "_rx_valid"},  rx_valid,    0);
        chk({tag, "_underrun"},  tx_underrun, 0);
        chk({tag, "_frame_err"}, frame_err,   0);
        chk({tag, "_busy"},      busy,        0);
    endtask

    // Mode-0 master: nbits bits from mo[], optional tx write right after
    // rising edge wr_bit, then CS release (or a reset when do_reset).
    task automatic run_frame(input int nbits, input int wr_bit, input logic [7:0] wr_val,
                             input bit do_reset);
        logic [7:0] slot;
        logic [7:0] rxsh;
        int b;
        int k;
        rxsh     = 8'h00;
        spi_cs   = 1'b0;
        spi_mosi = mo[0][7];
        model_load(slot);
        repeat (H) @(negedge clk);
        ur_at_start = dut_ur;
        for (int i = 0; i < nbits; i++) begin
            b = i / 8;
            k = i % 8;
            spi_sclk = 1'b1;
            rxsh = {rxsh[6:0], spi_miso};
            if (k == 7) begin
                got[b] = rxsh;
                chk("miso_byte", rxsh, slot);
                exp_rx.push_back(mo[b]);
            end
            if (i == wr_bit) begin
                tx_write(wr_val);
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            spi_sclk = 1'b0;
            if (k == 7) model_load(slot);
            if (i + 1 < nbits) spi_mosi = mo[(i + 1) / 8][7 - ((i + 1) % 8)];
            repeat (H) @(negedge clk);
        end
        if (do_reset) begin
            rst = 1'b1;
            @(negedge clk);
            check_reset("mid_reset");
            spi_cs   = 1'b1;
            spi_sclk = 1'b0;
            repeat (4) @(negedge clk);
            rst    = 1'b0;
            m_full = 1'b0;
        end else begin
            spi_cs = 1'b1;
            if (nbits % 8 != 0) exp_fe++;
        end
        repeat (10) @(negedge clk);
        chk("underrun_count", dut_ur, exp_ur);
        chk("frame_err_count", dut_fe, exp_fe);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_d = 1'b0;
            rxv_d  = 1'b0;
        end else begin
            if (rx_valid) begin
                dut_rxv++;
                chk("rx_valid_width", rxv_d, 0);
                if (exp_rx.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: got rx_byte %0h with nothing expected", rx_byte);
                end else begin
                    chk("rx_byte_stream", rx_byte, exp_rx.pop_front());
                end
            end
            if (tx_underrun) dut_ur++;
            if (frame_err) dut_fe++;
            if (!busy && !busy_d) chk("miso_idle", spi_miso, 0);
            busy_d = busy;
            rxv_d  = rx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int ur0;
    int fe0;
    int rv0;

    initial begin
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single byte
        tx_write(8'h3C);
        repeat (3) @(negedge clk);
        mo[0] = 8'hA5;
        run_frame(8, -1, 8'h00, 1'b0);
        chk("t1_master_got", got[0], 8'h3C);
        chk("t1_rx_byte", rx_byte, 8'hA5);
        chk("t1_tx_ready", tx_ready, 1);
        chk("t1_rx_valid_count", dut_rxv, 1);

        // underrun
        ur0 = dut_ur;
        mo[0] = 8'h12;
        run_frame(8, -1, 8'h00, 1'b0);
        chk("t2_underrun_at_cs_fall", ur_at_start - ur0, 1);
        chk("t2_master_got", got[0], 8'hFF);
        chk("t2_rx_byte", rx_byte, 8'h12);

        // back-to-back, second response queued while the first shifts
        tx_write(8'h11);
        repeat (3) @(negedge clk);
        mo[0] = 8'hC3;
        mo[1] = 8'h5A;
        run_frame(16, 3, 8'h22, 1'b0);
        chk("t3_master_got0", got[0], 8'h11);
        chk("t3_master_got1", got[1], 8'h22);
        chk("t3_rx_byte", rx_byte, 8'h5A);
        chk("t3_rx_valid_count", dut_rxv, 4);

        // abort after three bits, then a clean frame
        fe0 = dut_fe;
        rv0 = dut_rxv;
        mo[0] = 8'hF0;
        run_frame(3, -1, 8'h00, 1'b0);
        chk("t4_frame_err_pulses", dut_fe - fe0, 1);
        chk("t4_no_rx_valid", dut_rxv - rv0, 0);
        chk("t4_rx_byte_held", rx_byte, 8'h5A);
        mo[0] = 8'h81;
        run_frame(8, -1, 8'h00, 1'b0);
        chk("t4_rx_byte_after", rx_byte, 8'h81);

        // buffer full: second write dropped
        tx_write(8'h44);
        tx_write(8'h77);
        chk("t5_tx_ready_full", tx_ready, 0);
        repeat (3) @(negedge clk);
        mo[0] = 8'h0F;
        run_frame(8, -1, 8'h00, 1'b0);
        chk("t5_master_got", got[0], 8'h44);
        chk("t5_tx_ready_after", tx_ready, 1);

        // reset mid-frame with a byte queued, then a fresh frame
        mo[0] = 8'h6B;
        run_frame(4, 1, 8'h5E, 1'b1);
        mo[0] = 8'h96;
        run_frame(8, -1, 8'h00, 1'b0);
        chk("t6_rx_byte", rx_byte, 8'h96);
        chk("t6_master_got", got[0], 8'hFF);

        chk("rx_queue_drained", exp_rx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
